// File: rtl/cellram_burst_model.sv
// cellram_burst_model: synchronous-burst pseudo-SRAM (Cellular RAM) model.
// Define CELLRAM_ROW_WAIT_EN to insert row-boundary stalls in linear bursts.
//
// Ports:
//   clk, reset      device clock, synchronous active-high reset
//   ce, we, oe      active-low chip, write and output enables
//   adv             active-low address valid
//   cre             configuration register enable, active high
//   addr            word address, or BCR value when cre=1
//   be_n            active-low byte enables, bit i covers data[8i+7:8i]
//   data            bidirectional data bus
//   mem_wait        1 = data valid/accepted, high-Z while deselected
module cellram_burst_model #(
  parameter int ADDR_WIDTH = 23,
  parameter int DATA_WIDTH = 16,
  parameter int MEM_AWIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0] BCR_DEFAULT = 'h009D1F,
  parameter int ROW_WORDS = 128
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    ce,
  input  logic                    we,
  input  logic                    oe,
  input  logic                    adv,
  input  logic                    cre,
  input  logic [ADDR_WIDTH-1:0]   addr,
  input  logic [DATA_WIDTH/8-1:0] be_n,
  inout  wire  [DATA_WIDTH-1:0]   data,
  output wire                     mem_wait
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int DEPTH = 1 << MEM_AWIDTH;

`ifdef CELLRAM_ROW_WAIT_EN
  localparam bit ROW_WAIT = 1'b1;
`else
  localparam bit ROW_WAIT = 1'b0;
`endif

  typedef enum logic [2:0] {
    IDLE,
    CONFIG,
    LAT,
    READ,
    WRITE
  } state_t;

  state_t                  state;
  state_t                  state_nx;
  logic [ADDR_WIDTH-1:0]   bcr;
  logic [MEM_AWIDTH-1:0]   addr_ctr;
  logic [MEM_AWIDTH-1:0]   addr_inc;
  logic [MEM_AWIDTH-1:0]   addr_nx;
  logic [3:0]              cnt;
  logic [3:0]              stall_cnt;
  logic                    wr_dir;
  logic [2:0]              lat_code;
  logic [3:0]              lat;
  logic                    fixed_bl;
  logic                    wrap_en;
  logic [MEM_AWIDTH-1:0]   bl_mask;
  logic                    stall;
  logic                    row_cross;
  logic                    burst;
  logic                    wait_val;
  logic                    wait_oe;
  logic                    rd_oe;
  logic [DATA_WIDTH-1:0]   rd_word;
  logic                    unused_bcr;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // BCR field decode
  always_comb begin
    lat_code = bcr[13:11];
    lat      = 4'd3;
    if (lat_code >= 3'd2 && lat_code <= 3'd6)
      lat = {1'b0, lat_code};
  end

  always_comb begin
    fixed_bl = 1'b1;
    bl_mask  = '0;
    case (bcr[2:0])
      3'b001:  bl_mask = MEM_AWIDTH'(3);
      3'b010:  bl_mask = MEM_AWIDTH'(7);
      3'b011:  bl_mask = MEM_AWIDTH'(15);
      default: fixed_bl = 1'b0;
    endcase
  end

  assign wrap_en    = fixed_bl && !bcr[3];
  assign unused_bcr = ^{bcr[ADDR_WIDTH-1:14], bcr[10:4]};

  // Next burst address: wrap inside the aligned block or count linearly
  assign addr_inc = addr_ctr + MEM_AWIDTH'(1);
  assign addr_nx  = wrap_en
                  ? ((addr_ctr & ~bl_mask) | (addr_inc & bl_mask))
                  : addr_inc;

  assign row_cross = ROW_WAIT && !wrap_en
                  && ((addr_nx % MEM_AWIDTH'(ROW_WORDS)) == '0);
  assign stall     = (stall_cnt != 4'd0);

  // State register
  always_ff @(posedge clk) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_nx;
  end

  // Next state
  always_comb begin
    state_nx = state;
    if (ce) begin
      state_nx = IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (!adv)
            state_nx = cre ? CONFIG : LAT;
        end
        CONFIG: begin
          if (cnt == lat + 4'd1)
            state_nx = IDLE;
        end
        LAT: begin
          if (cnt == lat - 4'd1)
            state_nx = wr_dir ? WRITE : READ;
        end
        default: state_nx = state;
      endcase
    end
  end

  // Counters, BCR and burst address
  always_ff @(posedge clk) begin
    if (reset) begin
      bcr       <= BCR_DEFAULT;
      addr_ctr  <= '0;
      cnt       <= '0;
      stall_cnt <= '0;
      wr_dir    <= 1'b0;
    end else if (ce) begin
      addr_ctr  <= '0;
      cnt       <= '0;
      stall_cnt <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (!adv) begin
            cnt <= 4'd1;
            if (cre) begin
              bcr <= addr;
            end else begin
              addr_ctr <= addr[MEM_AWIDTH-1:0];
              wr_dir   <= !we;
            end
          end
        end
        CONFIG, LAT: begin
          cnt <= cnt + 4'd1;
        end
        READ, WRITE: begin
          if (stall) begin
            stall_cnt <= stall_cnt - 4'd1;
          end else begin
            addr_ctr <= addr_nx;
            if (row_cross)
              stall_cnt <= lat - 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Storage has no reset so contents survive a reset pulse
  always_ff @(posedge clk) begin
    if (!reset && !ce && state == WRITE && !stall) begin
      for (int i = 0; i < BYTES; i++) begin
        if (!be_n[i])
          mem[addr_ctr][8*i +: 8] <= data[8*i +: 8];
      end
    end
  end

  assign rd_word = mem[addr_ctr];

  // Pin drivers
  always_comb begin
    burst    = (state == READ) || (state == WRITE);
    wait_val = (burst && !stall)
            || (state == CONFIG && cnt == lat + 4'd1);
    wait_oe  = !ce && !reset;
    rd_oe    = !ce && !reset && !oe && we
            && (state == READ) && !stall;
  end

  assign mem_wait = wait_oe ? wait_val : 1'bz;
  assign data     = rd_oe ? rd_word : {DATA_WIDTH{1'bz}};

endmodule

// File: tb/tb_cellram_burst_model.sv
// tb_cellram_burst_model: scoreboard bench for cellram_burst_model.
// Reference model tracks BCR, memory contents and burst address order.
module tb_cellram_burst_model;

  localparam logic [22:0] BCR_DEF = 23'h009D1F;
  localparam int ROW = 128;

`ifdef CELLRAM_ROW_WAIT_EN
  localparam bit ROW_WAIT = 1'b1;
`else
  localparam bit ROW_WAIT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        ce;
  logic        we;
  logic        oe;
  logic        adv;
  logic        cre;
  logic [22:0] addr;
  logic [1:0]  be_n;
  wire  [15:0] data;
  wire         mem_wait;
  logic [15:0] tb_data;
  logic        tb_drv;

  assign data = tb_drv ? tb_data : 16'hzzzz;

  cellram_burst_model dut (
    .clk      (clk),
    .reset    (reset),
    .ce       (ce),
    .we       (we),
    .oe       (oe),
    .adv      (adv),
    .cre      (cre),
    .addr     (addr),
    .be_n     (be_n),
    .data     (data),
    .mem_wait (mem_wait)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [15:0] val;
    logic [1:0]  kn;
  } beat_t;

  typedef struct {
    int cyc;
    bit hiz;
    bit val;
  } wt_t;

  beat_t bq[$];
  wt_t   wq[$];

  logic [15:0] ref_mem [int];
  logic [1:0]  ref_kn  [int];
  logic [15:0] wdq[$];
  logic [1:0]  beq[$];

  int nvec = 0;
  int nerr = 0;
  bit done = 1'b0;
  int m_lat;
  int m_bl;
  bit m_wrap;

  function automatic void decode(input logic [22:0] b);
    int code;
    code = int'(b[13:11]);
    m_lat = (code >= 2 && code <= 6) ? code : 3;
    case (b[2:0])
      3'b001:  m_bl = 4;
      3'b010:  m_bl = 8;
      3'b011:  m_bl = 16;
      default: m_bl = 0;
    endcase
    m_wrap = (m_bl != 0) && (b[3] == 1'b0);
  endfunction

  function automatic int next_a(input int a);
    int base;
    if (m_wrap) begin
      base = a - (a % m_bl);
      return base + ((a - base + 1) % m_bl);
    end
    return (a + 1) % 65536;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_wait(input int c, input bit hiz, input bit v);
    wq.push_back('{cyc: c, hiz: hiz, val: v});
  endtask

  task automatic model_write(input int a, input logic [15:0] d,
                             input logic [1:0] b);
    logic [15:0] w;
    logic [1:0]  k;
    w = 16'h0;
    k = 2'b00;
    if (ref_mem.exists(a)) begin
      w = ref_mem[a];
      k = ref_kn[a];
    end
    for (int i = 0; i < 2; i++) begin
      if (!b[i]) begin
        w[8*i +: 8] = d[8*i +: 8];
        k[i] = 1'b1;
      end
    end
    ref_mem[a] = w;
    ref_kn[a]  = k;
  endtask

  task automatic push_read(input int a);
    logic [15:0] v;
    logic [1:0]  k;
    v = 16'h0;
    k = 2'b00;
    if (ref_mem.exists(a)) begin
      v = ref_mem[a];
      k = ref_kn[a];
    end
    bq.push_back('{cyc: cyc, val: v, kn: k});
  endtask

  // One access: adv edge, L-1 latency cycles, then ncyc burst cycles.
  // rst_at >= 0 pulses reset at that burst cycle instead.
  task automatic burst(input bit wr, input int start, input int ncyc,
                       input bit rnd, input int rst_at);
    int n;
    int a;
    int stall_left;
    logic [15:0] d;
    logic [1:0]  b;
    step();
    n    = cyc;
    ce   = 1'b0;
    adv  = 1'b0;
    cre  = 1'b0;
    we   = !wr;
    oe   = 1'b1;
    addr = {7'($urandom_range(0, 127)), 16'(start)};
    for (int t = 1; t < m_lat; t++) exp_wait(n + t, 1'b0, 1'b0);
    a = start % 65536;
    stall_left = 0;
    for (int t = 1; t < m_lat + ncyc; t++) begin
      step();
      adv = 1'b1;
      if (t >= m_lat) begin
        if (rnd) adv = ($urandom_range(0, 3) != 0);
        if (rst_at == t - m_lat) begin
          reset   = 1'b1;
          tb_drv  = 1'b1;
          tb_data = 16'($urandom);
          break;
        end
        if (stall_left > 0) begin
          stall_left--;
          exp_wait(cyc, 1'b0, 1'b0);
          if (wr) begin
            tb_drv  = 1'b1;
            tb_data = 16'($urandom);
            be_n    = 2'b00;
          end else begin
            oe = rnd ? ($urandom_range(0, 1) == 0) : 1'b0;
          end
        end else begin
          exp_wait(cyc, 1'b0, 1'b1);
          if (wr) begin
            d = (wdq.size() > 0) ? wdq.pop_front() : 16'($urandom);
            if (beq.size() > 0) b = beq.pop_front();
            else b = rnd ? 2'($urandom_range(0, 3)) : 2'b00;
            tb_drv  = 1'b1;
            tb_data = d;
            be_n    = b;
            model_write(a, d, b);
          end else begin
            oe = rnd ? ($urandom_range(0, 4) == 0) : 1'b0;
            we = rnd ? ($urandom_range(0, 5) != 0) : 1'b1;
            if (!oe && we) push_read(a);
          end
          n = next_a(a);
          if (ROW_WAIT && !m_wrap && (n % ROW) == 0)
            stall_left = m_lat - 1;
          a = n;
        end
      end
    end
    step();
    if (reset) decode(BCR_DEF);
    reset  = 1'b0;
    ce     = 1'b1;
    adv    = 1'b1;
    oe     = 1'b1;
    we     = 1'b1;
    tb_drv = 1'b0;
    be_n   = 2'b11;
    exp_wait(cyc, 1'b1, 1'b0);
  endtask

  task automatic cfg(input logic [22:0] v);
    int n;
    step();
    n    = cyc;
    ce   = 1'b0;
    cre  = 1'b1;
    adv  = 1'b0;
    we   = 1'($urandom_range(0, 1));
    addr = v;
    decode(v);
    for (int t = 1; t <= m_lat; t++) exp_wait(n + t, 1'b0, 1'b0);
    exp_wait(n + m_lat + 1, 1'b0, 1'b1);
    step();
    cre = 1'b0;
    adv = 1'b1;
    we  = 1'b1;
    repeat (m_lat) step();
    step();
    ce = 1'b1;
    exp_wait(cyc, 1'b1, 1'b0);
  endtask

  // Monitor: pops expectations when their cycle comes round
  always @(negedge clk) begin
    logic [15:0] m;
    if (!done) begin
      while (wq.size() > 0 && wq[0].cyc < cyc) begin
        nvec++;
        nerr++;
        $display("FAIL wait_lost cyc=%0d", wq[0].cyc);
        void'(wq.pop_front());
      end
      if (wq.size() > 0 && wq[0].cyc == cyc) begin
        nvec++;
        if (wq[0].hiz) begin
          if (mem_wait !== 1'bz) begin
            nerr++;
            $display("FAIL mem_wait cyc=%0d got=%b want=z", cyc, mem_wait);
          end
        end else if (mem_wait === 1'bz || mem_wait != wq[0].val) begin
          nerr++;
          $display("FAIL mem_wait cyc=%0d got=%b want=%b",
                   cyc, mem_wait, wq[0].val);
        end
        void'(wq.pop_front());
      end
      while (bq.size() > 0 && bq[0].cyc < cyc) begin
        nvec++;
        nerr++;
        $display("FAIL missing_beat cyc=%0d got=z want=%h",
                 bq[0].cyc, bq[0].val);
        void'(bq.pop_front());
      end
      if (!tb_drv && data !== 16'hzzzz) begin
        nvec++;
        if (bq.size() == 0 || bq[0].cyc != cyc) begin
          nerr++;
          $display("FAIL unexpected_beat cyc=%0d got=%h want=z", cyc, data);
        end else begin
          m = {{8{bq[0].kn[1]}}, {8{bq[0].kn[0]}}};
          if (((data ^ bq[0].val) & m) != 16'h0) begin
            nerr++;
            $display("FAIL read_data cyc=%0d got=%h want=%h",
                     cyc, data, bq[0].val);
          end
          void'(bq.pop_front());
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    logic [22:0] rb;
    int r;
    int s;
    reset   = 1'b1;
    ce      = 1'b1;
    we      = 1'b1;
    oe      = 1'b1;
    adv     = 1'b1;
    cre     = 1'b0;
    addr    = '0;
    be_n    = 2'b11;
    tb_drv  = 1'b0;
    tb_data = '0;
    decode(BCR_DEF);
    step();
    step();
    exp_wait(cyc, 1'b1, 1'b0);
    step();
    reset = 1'b0;

    wdq = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    burst(1'b1, 'h10, 4, 1'b0, -1);
    burst(1'b0, 'h10, 4, 1'b0, -1);

    burst(1'b1, 0, 256, 1'b0, -1);
    burst(1'b1, 'hFFF8, 16, 1'b0, -1);

    wdq = '{16'h0000};
    burst(1'b1, 'h20, 1, 1'b0, -1);
    wdq = '{16'hABCD};
    beq = '{2'b10};
    burst(1'b1, 'h20, 1, 1'b0, -1);
    burst(1'b0, 'h20, 1, 1'b0, -1);

    burst(1'b0, 126, 6, 1'b0, -1);
    burst(1'b0, 'hFFFE, 4, 1'b0, -1);
    burst(1'b0, 'h40, 3, 1'b0, -1);

    cfg(23'h001001);
    burst(1'b0, 6, 5, 1'b0, -1);
    burst(1'b1, 'h31, 6, 1'b0, -1);
    burst(1'b0, 'h30, 8, 1'b0, -1);

    repeat (60) begin
      r = $urandom_range(0, 9);
      s = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 255)
                                      : $urandom_range('hFFF0, 'hFFFF);
      if (r == 0) begin
        rb = 23'($urandom);
        rb[2:0] = 3'($urandom_range(0, 7));
        cfg(rb);
      end else begin
        burst(r >= 6, s, $urandom_range(0, 20), 1'b1, -1);
      end
    end

    cfg(23'h001001);
    burst(1'b1, 'h50, 6, 1'b0, 3);
    burst(1'b0, 'h50, 5, 1'b0, -1);
    burst(1'b0, 'h10, 4, 1'b0, -1);

    repeat (4) step();
    done = 1'b1;
    while (wq.size() > 0) begin
      nvec++;
      nerr++;
      $display("FAIL wait_left cyc=%0d", wq[0].cyc);
      void'(wq.pop_front());
    end
    while (bq.size() > 0) begin
      nvec++;
      nerr++;
      $display("FAIL beat_left cyc=%0d want=%h", bq[0].cyc, bq[0].val);
      void'(bq.pop_front());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
